// File: rtl/serial_add_scheduler_pkg.sv
// Shared state encoding and sizing helper for the serial add scheduler.
package serial_add_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Nibble counter width; a single-nibble operand still needs a 1-bit counter.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/look_ahead_adder.sv
// 4-bit carry-look-ahead adder slice: SUM/COUT = A + B + CIN.
module look_ahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = CIN;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign SUM  = p ^ c[3:0];
  assign COUT = c[4];

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one 4-bit look-ahead slice between two
// requesters; each WIDTH-bit add runs nibble-serially, LSB nibble first.
module serial_add_scheduler
  import serial_add_scheduler_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ0_CIN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic             REQ1_CIN,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_SUM,
  output logic             RES_COUT,
  output logic             RES_ID,
  output logic             BUSY
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("serial_add_scheduler: WIDTH must be a positive multiple of 4");
  end

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             res_id_q, res_id_d;

  logic             gnt0, gnt1, accept, last_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_shift;

  look_ahead_adder u_slice (
    .A    (a_q[3:0]),
    .B    (b_q[3:0]),
    .CIN  (carry_q),
    .SUM  (slice_sum),
    .COUT (slice_cout)
  );

  // Contention goes to the requester that was not granted last.
  assign gnt0     = REQ0_VALID & (~REQ1_VALID | last_q);
  assign gnt1     = REQ1_VALID & (~REQ0_VALID | ~last_q);
  assign accept   = (state_q == ST_IDLE) & (gnt0 | gnt1);
  assign last_nib = (cnt_q == LAST_NIB);
  assign sum_shift = (sum_q >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_ADD;
      ST_ADD:  if (last_nib)  state_d = ST_DONE;
      ST_DONE: if (RES_READY) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // READY is masked during reset so nothing is offered before IDLE is live.
  always_comb begin
    REQ0_READY = (state_q == ST_IDLE) & ~RST & gnt0;
    REQ1_READY = (state_q == ST_IDLE) & ~RST & gnt1;
    RES_VALID  = (state_q == ST_DONE);
    BUSY       = (state_q != ST_IDLE);
    RES_SUM    = res_sum_q;
    RES_COUT   = res_cout_q;
    RES_ID     = res_id_q;
  end

  always_comb begin
    last_d     = last_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    id_d       = id_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_id_d   = res_id_q;
    if (accept) begin
      a_d     = gnt0 ? REQ0_A   : REQ1_A;
      b_d     = gnt0 ? REQ0_B   : REQ1_B;
      carry_d = gnt0 ? REQ0_CIN : REQ1_CIN;
      id_d    = gnt1;
      last_d  = gnt1;
      cnt_d   = '0;
    end else if (state_q == ST_ADD) begin
      a_d     = a_q >> 4;
      b_d     = b_q >> 4;
      sum_d   = sum_shift;
      carry_d = slice_cout;
      cnt_d   = cnt_q + 1'b1;
      // Result registers load once so outputs stay put while RES_VALID is low.
      if (last_nib) begin
        res_sum_d  = sum_shift;
        res_cout_d = slice_cout;
        res_id_d   = id_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q     <= 1'b1;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      id_q       <= 1'b0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      id_q       <= id_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_id_q   <= res_id_d;
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler (WIDTH=16) with hand-computed sums.
module tb_serial_add_scheduler;

  localparam int WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic             REQ0_READY, REQ1_READY;
  logic [WIDTH-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic             REQ0_CIN = 1'b0, REQ1_CIN = 1'b0;
  logic             RES_VALID, RES_READY = 1'b0;
  logic [WIDTH-1:0] RES_SUM;
  logic             RES_COUT, RES_ID, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_scheduler #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A),
    .REQ0_B(REQ0_B), .REQ0_CIN(REQ0_CIN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A),
    .REQ1_B(REQ1_B), .REQ1_CIN(REQ1_CIN),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_SUM(RES_SUM),
    .RES_COUT(RES_COUT), .RES_ID(RES_ID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges after the accept edge until RES_VALID; NIB=4 gives 4.
  task automatic wait_result(input string tag, output int edges);
    edges = 0;
    while (!RES_VALID && edges < 20) begin
      step();
      edges++;
    end
    check({tag, "_latency"}, edges, 4);
  endtask

  // One isolated operation from IDLE, result consumed immediately.
  task automatic do_op(input string tag, input logic id, input logic [15:0] a,
                       input logic [15:0] b, input logic cin,
                       input logic [15:0] exp_sum, input logic exp_cout);
    int edges;
    if (id) begin REQ1_A = a; REQ1_B = b; REQ1_CIN = cin; REQ1_VALID = 1'b1; end
    else    begin REQ0_A = a; REQ0_B = b; REQ0_CIN = cin; REQ0_VALID = 1'b1; end
    #1;
    check({tag, "_ready"}, id ? REQ1_READY : REQ0_READY, 1);
    step();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    check({tag, "_busy"}, BUSY, 1);
    wait_result(tag, edges);
    check({tag, "_sum"}, RES_SUM, exp_sum);
    check({tag, "_cout"}, RES_COUT, exp_cout);
    check({tag, "_id"}, RES_ID, id);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    check({tag, "_idle"}, BUSY, 0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin : main
    int edges;
    int n_acc;
    int n_res;
    logic exp_order [4];
    logic got_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    got_order = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles with a pending request.
    REQ0_VALID = 1'b1;
    REQ0_A = 16'h1234;
    REQ0_B = 16'h4321;
    step();
    step();
    check("rst_ready0", REQ0_READY, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_sum", RES_SUM, 0);
    RST = 1'b0;
    #1;
    check("post_rst_ready0", REQ0_READY, 1);
    REQ0_VALID = 1'b0;
    #1;

    do_op("single", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    do_op("ripple_all", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    do_op("ripple_byte", 1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // Round-robin with both requesters continuously valid.
    pulse_reset();
    REQ0_A = 16'h0001; REQ0_B = 16'h0001; REQ0_CIN = 1'b0;
    REQ1_A = 16'h8000; REQ1_B = 16'h8000; REQ1_CIN = 1'b0;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    RES_READY  = 1'b1;
    #1;
    n_acc = 0;
    n_res = 0;
    for (int cyc = 0; cyc < 60 && n_res < 4; cyc++) begin
      if (REQ0_READY && n_acc < 4) begin got_order[n_acc] = 1'b0; n_acc++; end
      else if (REQ1_READY && n_acc < 4) begin got_order[n_acc] = 1'b1; n_acc++; end
      if (RES_VALID) begin
        check("rr_res_id", RES_ID, exp_order[n_res]);
        check("rr_sum", RES_SUM, exp_order[n_res] ? 16'h0000 : 16'h0002);
        check("rr_cout", RES_COUT, exp_order[n_res] ? 1 : 0);
        n_res++;
      end
      step();
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RES_READY  = 1'b0;
    check("rr_results", n_res, 4);
    for (int i = 0; i < 4; i++) check("rr_accept_order", got_order[i], exp_order[i]);
    step();
    step();
    step();
    step();
    step();
    step();
    step();
    check("rr_drained", BUSY, 0);

    // Backpressure: result held while REQ1 waits.
    pulse_reset();
    REQ0_A = 16'h00FF; REQ0_B = 16'h0001; REQ0_CIN = 1'b0;
    REQ0_VALID = 1'b1;
    step();
    REQ0_VALID = 1'b0;
    REQ1_A = 16'h0010; REQ1_B = 16'h0020; REQ1_CIN = 1'b1;
    REQ1_VALID = 1'b1;
    wait_result("bp", edges);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", RES_VALID, 1);
      check("bp_sum", RES_SUM, 16'h0100);
      check("bp_id", RES_ID, 0);
      check("bp_ready1", REQ1_READY, 0);
      step();
    end
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    check("bp_idle", BUSY, 0);
    check("bp_ready1_after", REQ1_READY, 1);
    step();
    REQ1_VALID = 1'b0;
    wait_result("bp_r1", edges);
    check("bp_r1_sum", RES_SUM, 16'h0031);
    check("bp_r1_id", RES_ID, 1);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;

    // Reset during the second ADD cycle aborts the operation.
    REQ0_A = 16'h1111; REQ0_B = 16'h1111; REQ0_CIN = 1'b0;
    REQ0_VALID = 1'b1;
    step();
    REQ0_VALID = 1'b0;
    step();
    check("abort_busy_pre", BUSY, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("abort_idle", BUSY, 0);
    check("abort_res_valid", RES_VALID, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", RES_VALID, 0);
    end
    do_op("after_abort", 1'b0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Time-shares one 4-bit carry-look-ahead adder slice between two requesters. Each request is a WIDTH-bit add.
- The block arbitrates between the requesters round-robin.
- It latches the operands, then feeds the slice one nibble per cycle, LSB nibble first, with the carry registered between nibbles.
- It returns the sum, carry-out and requester ID over a valid/ready result port.
- It sits between the operand-issuing logic and any consumer that needs wide sums without a full-width adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ0_VALID  in  1  requester 0 has an operation
- REQ0_READY  out  1  requester 0 operation accepted this cycle
- REQ0_A  in  WIDTH  requester 0 operand A
- REQ0_B  in  WIDTH  requester 0 operand B
- REQ0_CIN  in  1  requester 0 carry-in
- REQ1_VALID / REQ1_READY / REQ1_A / REQ1_B / REQ1_CIN  same as requester 0, for requester 1
- RES_VALID  out  1  result available
- RES_READY  in  1  consumer takes result
- RES_SUM  out  WIDTH  A+B+CIN mod 2^WIDTH
- RES_COUT  out  1  carry out of bit WIDTH-1
- RES_ID  out  1  requester that issued the operation
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: RST sampled high at an edge → state IDLE. All outputs 0. Round-robin pointer LAST=1, so requester 0 wins the first contention. Operand, sum and carry registers cleared.
- RST asserted during ADD or DONE aborts the operation. That result is never presented.
- State IDLE:
  - Grant: if only one VALID is high, grant it. If both are high, grant the requester != LAST.
  - REQx_READY is high only for the granted requester, only in IDLE. It is combinational from the VALIDs.
  - Requesters must not derive VALID from READY. VALID and operands must stay stable until READY.
  - On VALID&READY: latch A, B, CIN and ID; set LAST=ID; clear nibble counter; go to ADD.
- State ADD, lasts exactly NIB=WIDTH/4 cycles. Each cycle:
  - The slice adds A_sh[3:0], B_sh[3:0] and carry_q. carry_q starts at the latched CIN.
  - The slice sum nibble shifts into the sum register from the MSB side.
  - carry_q takes the slice COUT. A_sh and B_sh shift right by 4.
  - The counter increments. When the counter reaches NIB-1, the next state is DONE.
- State DONE:
  - RES_VALID=1. RES_SUM, RES_COUT and RES_ID are held stable until RES_VALID&RES_READY, then go to IDLE.
  - Both REQx_READY stay 0 while in DONE.
- Latency:
  - Accept in cycle 0; ADD in cycles 1..NIB; RES_VALID first high in cycle NIB+1. WIDTH=16 gives cycle 5.
  - Best-case throughput is one operation per NIB+2 cycles. There is no accept in the same cycle as the result handshake.
- Arithmetic: unsigned. Wrap-around is mod 2^WIDTH. RES_COUT is the final carry_q.
- Outputs when RES_VALID=0: RES_SUM, RES_COUT and RES_ID keep their last values (0 after reset) and are don't-care to the consumer.
- The round-robin pointer updates only on accept. A requester dropping VALID does not change LAST.

Decomposition:
- Shared constants header: state encodings IDLE=2'd0, ADD=2'd1, DONE=2'd2; NIB=WIDTH/4; counter width clog2(NIB) with a minimum of 1.
- One sub-module: the existing 4-bit carry-look-ahead slice look_ahead_adder (A, B, CIN, SUM, COUT), instantiated once.
- The arbiter and FSM are inline; no separate arbiter module.

Test Plan:
- Reset: hold RST 2 cycles with REQ0_VALID=1 → REQ0_READY=0, RES_VALID=0, BUSY=0. First cycle after release: REQ0_READY=1.
- Single op, WIDTH=16: A=0x1234, B=0x4321, CIN=0 accepted at cycle 0 → cycle 5: RES_VALID=1, SUM=0x5555, COUT=0, ID=0.
- Full ripple: A=0xFFFF, B=0x0000, CIN=1 → SUM=0x0000, COUT=1. Also A=0x00FF, B=0x0001, CIN=0 → SUM=0x0100, COUT=0.
- Round-robin: both VALID held with RES_READY=1; REQ0 A=1, B=1; REQ1 A=0x8000, B=0x8000.
  - Accept order is 0,1,0,1.
  - ID0 results: SUM=0x0002, COUT=0. ID1 results: SUM=0x0000, COUT=1.
- Backpressure: RES_READY=0 for 3 cycles in DONE with REQ1_VALID=1 → outputs held, REQ1_READY=0. After the handshake: IDLE, then REQ1 accepted.
- Reset mid-op: RST in the 2nd ADD cycle → no RES_VALID for that op, IDLE next cycle. A new op A=3, B=4 then completes with SUM=7.
